// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the i2s stream controller.
//   - state_t      : controller state encoding (CHARGE / MUTE / RUN)
//   - FRAME_BITS   : width of the free-running frame counter
//   - ARB_POS      : half-frame position where the accept pulse is issued
//   - DEF_*        : default charge-delay exponent and mute frame count
package i2s_pkg;

  localparam int FRAME_BITS      = 8;
  localparam int ARB_POS         = 1;
  localparam int CHARGE_CNT_W    = 24;
  localparam int MUTE_CNT_W      = 16;
  localparam int DEF_CHARGE_BITS = 23;
  localparam int DEF_MUTE_FRAMES = 10;

  typedef enum logic [1:0] {
    ST_CHARGE = 2'd0,
    ST_MUTE   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_stream_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   : request vector, N bits
//   ptr   : index of the last granted requester; search starts at ptr+1 mod N
//   grant : one-hot grant (all zero when nothing requests)
//   any   : 1 when some requester was granted
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any
);

  always_comb begin
    int k;
    grant = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        grant[k] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_stream_ctrl.sv
// i2s_stream_ctrl: power-up sequencer and sample feeder for an i2s core.
//
// Runs the CS4344 start-up: 2^CHARGE_BITS clocks of MCLK only, then
// MUTE_FRAMES zero frames, then live audio. In RUN, one sample per channel
// half-frame is taken round-robin from NREQ sources and held on o_sample
// from half-frame position 2 up to the next arbitration, covering the
// core's load at position 4.
//
// Ports:
//   clk            master clock (shared with the i2s core)
//   resetn         asynchronous active-low reset
//   i_req_valid    per-source sample pending
//   i_req_data     per-source sample, source n in [n*WIDTH +: WIDTH]
//   o_req_ready    one-hot 1-cycle accept pulse
//   i_mute         level; forces zero output and blocks accepts
//   o_sample       registered sample to the core
//   o_run          1 once the charge delay has elapsed
//   o_frame_strobe 1-cycle pulse while the frame counter is 0
//   o_underrun     1-cycle pulse when a live slot found no valid source
//   o_state        0=CHARGE, 1=MUTE, 2=RUN
//
// Handshake: a source raises i_req_valid with i_req_data and keeps both
// stable until o_req_ready[n] pulses; the sample is taken in the ready
// cycle. Valid may drop without an accept. Ready is never issued to a
// source whose valid was low when the slot was arbitrated.
//
// Build option I2S_STREAM_HOLD_LAST_EN: on underrun o_sample keeps its
// last value instead of going to zero.
module i2s_stream_ctrl
  import i2s_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int CHARGE_BITS = DEF_CHARGE_BITS,
  parameter int MUTE_FRAMES = DEF_MUTE_FRAMES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic                  i_mute,
  output logic [WIDTH-1:0]      o_sample,
  output logic                  o_run,
  output logic                  o_frame_strobe,
  output logic                  o_underrun,
  output logic [1:0]            o_state
);

  localparam int PTR_W  = $clog2(NREQ);
  localparam int HALF_W = FRAME_BITS - 1;
  localparam logic [MUTE_CNT_W-1:0] MUTE_LAST = MUTE_CNT_W'(MUTE_FRAMES - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   fcnt_q;
  logic [CHARGE_CNT_W-1:0] charge_q, charge_d, charge_inc;
  logic [MUTE_CNT_W-1:0]   mute_cnt_q, mute_cnt_d;
  logic                    mute_pend_q, mute_pend_d;
  logic [PTR_W-1:0]        ptr_q;

  logic                    strobe_ev;
  logic                    arb_ev;
  logic                    load_ev;
  logic [NREQ-1:0]         grant;
  logic                    grant_any;
  logic [PTR_W-1:0]        grant_idx;
  logic [WIDTH-1:0]        sel_data;

  // Events are decoded one cycle early so that the registered outputs
  // line up with the frame counter value they belong to.
  assign strobe_ev  = (fcnt_q == '1);
  assign arb_ev     = (int'(fcnt_q[HALF_W-1:0]) == ARB_POS - 1);
  assign load_ev    = (int'(fcnt_q[HALF_W-1:0]) == ARB_POS);
  assign charge_inc = charge_q + 1'b1;
  assign o_state    = state_q;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (grant_any)
  );

  always_comb begin
    grant_idx = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (grant[n]) grant_idx = PTR_W'(n);
    end
  end

  // Data of the source currently holding the registered ready pulse.
  always_comb begin
    sel_data = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (o_req_ready[n]) sel_data = sel_data | i_req_data[n*WIDTH +: WIDTH];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_CHARGE;
      charge_q    <= '0;
      mute_cnt_q  <= '0;
      mute_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      charge_q    <= charge_d;
      mute_cnt_q  <= mute_cnt_d;
      mute_pend_q <= mute_pend_d;
    end
  end

  // FSM next state. State changes to/from RUN happen on the edge that
  // brings the frame counter to 0, so the new state is visible together
  // with o_frame_strobe.
  always_comb begin
    state_d     = state_q;
    charge_d    = charge_q;
    mute_cnt_d  = mute_cnt_q;
    mute_pend_d = mute_pend_q;
    case (state_q)
      ST_CHARGE: begin
        charge_d = charge_inc;
        if (charge_inc[CHARGE_BITS]) begin
          state_d    = ST_MUTE;
          mute_cnt_d = '0;
        end
      end
      ST_MUTE: begin
        mute_pend_d = 1'b0;
        if (i_mute) begin
          // A mute request also wins over reaching the frame count.
          mute_cnt_d = '0;
        end else if (strobe_ev) begin
          if (mute_cnt_q == MUTE_LAST) begin
            state_d    = ST_RUN;
            mute_cnt_d = '0;
          end else begin
            mute_cnt_d = mute_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Remember a mute request so the current frame completes first.
        if (i_mute) mute_pend_d = 1'b1;
        if (strobe_ev && (mute_pend_q || i_mute)) begin
          state_d     = ST_MUTE;
          mute_cnt_d  = '0;
          mute_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CHARGE;
      end
    endcase
  end

  // Frame counter, arbitration and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fcnt_q         <= '0;
      ptr_q          <= '0;
      o_req_ready    <= '0;
      o_underrun     <= 1'b0;
      o_frame_strobe <= 1'b0;
      o_run          <= 1'b0;
      o_sample       <= '0;
    end else begin
      fcnt_q         <= fcnt_q + 1'b1;
      o_frame_strobe <= strobe_ev;
      o_run          <= (state_d != ST_CHARGE);
      o_req_ready    <= '0;
      o_underrun     <= 1'b0;

      // Arbitrate for the slot whose ready cycle is the next one.
      if (arb_ev && (state_d == ST_RUN) && !i_mute) begin
        if (grant_any) begin
          o_req_ready <= grant;
          ptr_q       <= grant_idx;
        end else begin
          o_underrun <= 1'b1;
        end
      end

      if (state_d != ST_RUN) begin
        o_sample <= '0;
      end else if (load_ev) begin
        if (|o_req_ready) begin
          o_sample <= sel_data;
        end else if (o_underrun) begin
`ifdef I2S_STREAM_HOLD_LAST_EN
          o_sample <= o_sample;
`else
          o_sample <= '0;
`endif
        end else begin
          // Slot suppressed by a mute request.
          o_sample <= '0;
        end
      end
    end
  end

endmodule
